// File: rtl/ro_scheduler_if.sv
// Readout scheduler bus: per-channel inputs towards the scheduler and the
// serialised readout stream back from it.
//   master : drives en, latch_mode, in_eve, in_pol_eve; observes the outputs
//   slave  : the scheduler itself
interface ro_scheduler_if #(
   parameter int unsigned N_CH = 8,
   parameter int unsigned CH_W = 3
);
   logic            en;
   logic            latch_mode;
   logic [N_CH-1:0] in_eve;
   logic [N_CH-1:0] in_pol_eve;
   logic [N_CH-1:0] gray;
   logic            out_mux_eve;
   logic            out_mux_pol_eve;
   logic [CH_W-1:0] out_ch;
   logic            out_valid;
   logic            out_ovf;
   logic            frame;

   modport master (
      output en, latch_mode, in_eve, in_pol_eve,
      input  gray, out_mux_eve, out_mux_pol_eve, out_ch, out_valid, out_ovf, frame
   );

   modport slave (
      input  en, latch_mode, in_eve, in_pol_eve,
      output gray, out_mux_eve, out_mux_pol_eve, out_ch, out_valid, out_ovf, frame
   );
endinterface

// File: rtl/ro_scheduler.sv
// Binary-weighted readout scheduler. A free-running slot counter (enabled by
// bus.en) decodes to a frame slot (cnt==0) or to channel k = trailing zeros of
// cnt, so channel k is read once every 2^(k+1) cycles. The served channel's
// event/polarity bits are registered onto one output pair together with the
// channel index, valid, frame and overflow flags. In sticky mode per-channel
// latches hold events that arrive between a channel's slots.
// Ports:
//   clk_master : master clock, all state on its rising edge
//   reset      : asynchronous active-high reset
//   bus        : ro_scheduler_if slave (en, latch_mode, in_eve, in_pol_eve in;
//                gray, out_mux_eve, out_mux_pol_eve, out_ch, out_valid,
//                out_ovf, frame out)
module ro_scheduler #(
   parameter int unsigned N_CH = 8,
   parameter int unsigned CH_W = 3
) (
   input logic           clk_master,
   input logic           reset,
   ro_scheduler_if.slave bus
);

   logic [N_CH-1:0] cnt_q, cnt_d, gray_q;
   logic [N_CH-1:0] ev_lat_q, ev_lat_d;
   logic [N_CH-1:0] pol_lat_q, pol_lat_d;
   logic [N_CH-1:0] ovf_lat_q, ovf_lat_d;

   logic [N_CH-1:0] slot_mask;    // one-hot owner of the current slot, 0 on frame slot
   logic [N_CH-1:0] served_mask;  // slot_mask qualified by en
   logic [N_CH-1:0] hit;
   logic [CH_W-1:0] slot_ch;
   logic            slot_frame;

   logic in_e, in_p, lat_e, lat_p, lat_o;
   logic srv_eve, srv_pol, srv_ovf;

   logic [CH_W-1:0] ch_q, ch_d;
   logic valid_q, valid_d, frame_q, frame_d;
   logic eve_q, eve_d, pol_q, pol_d, ovf_q, ovf_d;

   // Slot decode: isolating the lowest set bit gives the owner channel.
   always_comb begin
      slot_frame  = (cnt_q == '0);
      slot_mask   = cnt_q & (~cnt_q + N_CH'(1));
      served_mask = bus.en ? slot_mask : '0;
      slot_ch     = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (slot_mask[i]) slot_ch = CH_W'(i);
      end
   end

   // Served channel data.
   always_comb begin
      in_e  = |(bus.in_eve & slot_mask);
      in_p  = |(bus.in_pol_eve & slot_mask);
      lat_e = |(ev_lat_q & slot_mask);
      lat_p = |(pol_lat_q & slot_mask);
      lat_o = |(ovf_lat_q & slot_mask);
      if (bus.latch_mode) begin
         srv_eve = lat_e | in_e;
         srv_pol = (in_e ? in_p : lat_p) & srv_eve;
         srv_ovf = lat_o | (lat_e & in_e);
      end else begin
         srv_eve = in_e;
         srv_pol = in_p & in_e;
         srv_ovf = 1'b0;
      end
   end

   // Capture latches: the served channel is cleared, others accumulate.
   // Latch updates run regardless of en so stalls never drop events.
   always_comb begin
      hit       = bus.in_eve & ~served_mask;
      ev_lat_d  = (ev_lat_q | hit) & ~served_mask;
      pol_lat_d = ((pol_lat_q & ~hit) | (bus.in_pol_eve & hit)) & ~served_mask;
      ovf_lat_d = (ovf_lat_q | (ev_lat_q & hit)) & ~served_mask;
      if (!bus.latch_mode) begin
         ev_lat_d  = '0;
         pol_lat_d = '0;
         ovf_lat_d = '0;
      end
   end

   // Counter and output register next state.
   always_comb begin
      cnt_d   = bus.en ? cnt_q + N_CH'(1) : cnt_q;
      ch_d    = ch_q;
      valid_d = 1'b0;
      frame_d = 1'b0;
      eve_d   = 1'b0;
      pol_d   = 1'b0;
      ovf_d   = 1'b0;
      if (bus.en) begin
         if (slot_frame) begin
            frame_d = 1'b1;
            ch_d    = '0;
         end else begin
            valid_d = 1'b1;
            ch_d    = slot_ch;
            eve_d   = srv_eve;
            pol_d   = srv_pol;
            ovf_d   = srv_ovf;
         end
      end
   end

   always_ff @(posedge clk_master or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         gray_q    <= '0;
         ev_lat_q  <= '0;
         pol_lat_q <= '0;
         ovf_lat_q <= '0;
         ch_q      <= '0;
         valid_q   <= 1'b0;
         frame_q   <= 1'b0;
         eve_q     <= 1'b0;
         pol_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         gray_q    <= cnt_d ^ (cnt_d >> 1);
         ev_lat_q  <= ev_lat_d;
         pol_lat_q <= pol_lat_d;
         ovf_lat_q <= ovf_lat_d;
         ch_q      <= ch_d;
         valid_q   <= valid_d;
         frame_q   <= frame_d;
         eve_q     <= eve_d;
         pol_q     <= pol_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.gray            = gray_q;
   assign bus.out_ch          = ch_q;
   assign bus.out_valid       = valid_q;
   assign bus.frame           = frame_q;
   assign bus.out_mux_eve     = eve_q;
   assign bus.out_mux_pol_eve = pol_q;
   assign bus.out_ovf         = ovf_q;

endmodule

// File: tb/tb_ro_scheduler.sv
// Bench for ro_scheduler: a vector table, hand-written latch/reset sequences
// and a randomized run, all compared against an event-count reference model.
module tb_ro_scheduler;
   localparam int unsigned N_CH = 8;
   localparam int unsigned CH_W = 3;

   logic clk_master = 1'b0;
   logic reset      = 1'b1;
   always #5 clk_master = ~clk_master;

   ro_scheduler_if #(.N_CH(N_CH), .CH_W(CH_W)) bus ();

   ro_scheduler #(.N_CH(N_CH), .CH_W(CH_W)) dut (
      .clk_master(clk_master),
      .reset     (reset),
      .bus       (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: slot position, and per channel the number of events
   // seen since its last slot (saturating at 2) plus the latest polarity.
   int   m_cnt;
   int   m_ch;
   int   m_pend[N_CH];
   logic m_last_pol[N_CH];

   logic [N_CH-1:0] x_gray;
   logic [CH_W-1:0] x_ch;
   logic            x_valid, x_frame, x_eve, x_pol, x_ovf;

   typedef struct {
      logic            en;
      logic [N_CH-1:0] ev;
      logic [N_CH-1:0] pv;
      logic [N_CH-1:0] gray;
      logic [CH_W-1:0] ch;
      logic            valid;
      logic            frame;
      logic            eve;
      logic            pol;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int low_bit(input int c);
      int v = c;
      int k = 0;
      while ((v % 2) == 0) begin
         v = v / 2;
         k++;
      end
      return k;
   endfunction

   task automatic reset_model();
      m_cnt = 0;
      m_ch  = 0;
      for (int j = 0; j < N_CH; j++) begin
         m_pend[j]     = 0;
         m_last_pol[j] = 1'b0;
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".gray"},  32'(bus.gray), 0);
      chk({tag, ".ch"},    32'(bus.out_ch), 0);
      chk({tag, ".valid"}, 32'(bus.out_valid), 0);
      chk({tag, ".frame"}, 32'(bus.frame), 0);
      chk({tag, ".eve"},   32'(bus.out_mux_eve), 0);
      chk({tag, ".pol"},   32'(bus.out_mux_pol_eve), 0);
      chk({tag, ".ovf"},   32'(bus.out_ovf), 0);
   endtask

   // One clock: drive inputs, predict, clock, compare against the model.
   task automatic step(input logic e, input logic lm, input logic [N_CH-1:0] ev,
                       input logic [N_CH-1:0] pv);
      int k;
      int total;
      bus.en         = e;
      bus.latch_mode = lm;
      bus.in_eve     = ev;
      bus.in_pol_eve = pv;
      x_valid = 1'b0;
      x_frame = 1'b0;
      x_eve   = 1'b0;
      x_pol   = 1'b0;
      x_ovf   = 1'b0;
      x_ch    = CH_W'(m_ch);
      k       = -1;
      if (e) begin
         if (m_cnt == 0) begin
            x_frame = 1'b1;
            x_ch    = '0;
         end else begin
            k       = low_bit(m_cnt);
            x_valid = 1'b1;
            x_ch    = CH_W'(k);
            if (!lm) begin
               x_eve = ev[k];
               x_pol = ev[k] & pv[k];
            end else begin
               total = m_pend[k] + int'(ev[k]);
               x_eve = (total >= 1);
               x_ovf = (total >= 2);
               x_pol = x_eve & (ev[k] ? pv[k] : m_last_pol[k]);
            end
         end
      end
      for (int j = 0; j < N_CH; j++) begin
         if (!lm || j == k) m_pend[j] = 0;
         else if (ev[j]) begin
            if (m_pend[j] < 2) m_pend[j]++;
            m_last_pol[j] = pv[j];
         end
      end
      if (e) m_cnt = (m_cnt + 1) % (1 << N_CH);
      m_ch   = int'(x_ch);
      x_gray = N_CH'(m_cnt ^ (m_cnt / 2));
      @(posedge clk_master);
      #1;
      chk("gray",  32'(bus.gray), 32'(x_gray));
      chk("ch",    32'(bus.out_ch), 32'(x_ch));
      chk("valid", 32'(bus.out_valid), 32'(x_valid));
      chk("frame", 32'(bus.frame), 32'(x_frame));
      chk("eve",   32'(bus.out_mux_eve), 32'(x_eve));
      chk("pol",   32'(bus.out_mux_pol_eve), 32'(x_pol));
      chk("ovf",   32'(bus.out_ovf), 32'(x_ovf));
   endtask

   // Reset asserted between edges; outputs must clear without a clock.
   task automatic do_reset(input string tag);
      bus.en         = 1'b0;
      bus.latch_mode = 1'b0;
      bus.in_eve     = '0;
      bus.in_pol_eve = '0;
      reset = 1'b1;
      #1;
      check_zero(tag);
      @(negedge clk_master);
      reset = 1'b0;
      reset_model();
   endtask

   task automatic run_to(input int target, input logic lm);
      int guard = 0;
      while (m_cnt != target && guard < 600) begin
         step(1'b1, lm, '0, '0);
         guard++;
      end
      chk("run_to_reached", 32'(m_cnt), 32'(target));
   endtask

   initial begin
      vec_t vt[10];
      int   seq[8];
      int   frames, valids;
      logic lm_r;
      logic [N_CH-1:0] ev_r;

      //           en ev     pv     gray   ch valid frame eve pol
      vt[0] = '{1'b1, 8'h01, 8'h01, 8'h01, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[1] = '{1'b1, 8'h01, 8'h01, 8'h03, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1};
      vt[2] = '{1'b1, 8'h01, 8'h00, 8'h02, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[3] = '{1'b0, 8'h02, 8'h02, 8'h02, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[4] = '{1'b1, 8'h01, 8'h00, 8'h06, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[5] = '{1'b1, 8'h04, 8'h04, 8'h07, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1};
      vt[6] = '{1'b1, 8'h02, 8'h02, 8'h05, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[7] = '{1'b1, 8'h02, 8'h02, 8'h04, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1};
      vt[8] = '{1'b1, 8'h00, 8'hFF, 8'h0C, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[9] = '{1'b1, 8'h08, 8'h08, 8'h0D, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1};
      seq = '{0, 1, 0, 2, 0, 1, 0, 3};

      bus.en = 1'b0;
      bus.latch_mode = 1'b0;
      bus.in_eve = '0;
      bus.in_pol_eve = '0;
      #12;
      check_zero("por");
      @(negedge clk_master);
      reset = 1'b0;
      reset_model();

      // Level-sample vectors including a stall that holds out_ch.
      for (int i = 0; i < 10; i++) begin
         step(vt[i].en, 1'b0, vt[i].ev, vt[i].pv);
         chk($sformatf("vec%0d.gray", i),  32'(bus.gray), 32'(vt[i].gray));
         chk($sformatf("vec%0d.ch", i),    32'(bus.out_ch), 32'(vt[i].ch));
         chk($sformatf("vec%0d.valid", i), 32'(bus.out_valid), 32'(vt[i].valid));
         chk($sformatf("vec%0d.frame", i), 32'(bus.frame), 32'(vt[i].frame));
         chk($sformatf("vec%0d.eve", i),   32'(bus.out_mux_eve), 32'(vt[i].eve));
         chk($sformatf("vec%0d.pol", i),   32'(bus.out_mux_pol_eve), 32'(vt[i].pol));
         chk($sformatf("vec%0d.ovf", i),   32'(bus.out_ovf), 0);
      end

      // Two full frames with idle inputs: frame rate, valid count, order, wrap.
      do_reset("rst_sweep");
      frames = 0;
      valids = 0;
      for (int i = 0; i < 512; i++) begin
         step(1'b1, 1'b0, '0, '0);
         if (bus.frame) frames++;
         if (bus.out_valid) valids++;
         if (i >= 1 && i <= 8) chk($sformatf("order%0d", i), 32'(bus.out_ch), 32'(seq[i-1]));
      end
      chk("frames_per_512", 32'(frames), 2);
      chk("valids_per_512", 32'(valids), 510);

      // Level mode with ch0 event held high.
      for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 8'h01, 8'h01);

      // Sticky: ch3 pulse at cnt=9, reported at cnt=24 only.
      do_reset("rst_ch3");
      run_to(9, 1'b1);
      step(1'b1, 1'b1, 8'h08, 8'h00);
      run_to(24, 1'b1);
      step(1'b1, 1'b1, '0, '0);
      chk("ch3.ch", 32'(bus.out_ch), 3);
      chk("ch3.eve", 32'(bus.out_mux_eve), 1);
      chk("ch3.pol", 32'(bus.out_mux_pol_eve), 0);
      chk("ch3.ovf", 32'(bus.out_ovf), 0);
      run_to(40, 1'b1);
      step(1'b1, 1'b1, '0, '0);
      chk("ch3_next.eve", 32'(bus.out_mux_eve), 0);

      // Sticky: two ch7 pulses, last polarity wins, overflow flagged once.
      do_reset("rst_ch7");
      run_to(10, 1'b1);
      step(1'b1, 1'b1, 8'h80, 8'h80);
      run_to(50, 1'b1);
      step(1'b1, 1'b1, 8'h80, 8'h00);
      run_to(128, 1'b1);
      step(1'b1, 1'b1, '0, '0);
      chk("ch7.ch", 32'(bus.out_ch), 7);
      chk("ch7.eve", 32'(bus.out_mux_eve), 1);
      chk("ch7.pol", 32'(bus.out_mux_pol_eve), 0);
      chk("ch7.ovf", 32'(bus.out_ovf), 1);
      run_to(0, 1'b1);
      run_to(128, 1'b1);
      step(1'b1, 1'b1, '0, '0);
      chk("ch7_next.ovf", 32'(bus.out_ovf), 0);
      chk("ch7_next.eve", 32'(bus.out_mux_eve), 0);

      // Sticky: pulse coinciding with the ch0 slot, then with ev_lat set.
      do_reset("rst_ch0");
      run_to(5, 1'b1);
      step(1'b1, 1'b1, 8'h01, 8'h01);
      chk("ch0.eve", 32'(bus.out_mux_eve), 1);
      chk("ch0.pol", 32'(bus.out_mux_pol_eve), 1);
      chk("ch0.ovf", 32'(bus.out_ovf), 0);
      step(1'b1, 1'b1, '0, '0);
      step(1'b1, 1'b1, '0, '0);
      chk("ch0_next.eve", 32'(bus.out_mux_eve), 0);
      step(1'b1, 1'b1, 8'h01, 8'h01);
      step(1'b1, 1'b1, 8'h01, 8'h00);
      chk("ch0_ovf.eve", 32'(bus.out_mux_eve), 1);
      chk("ch0_ovf.pol", 32'(bus.out_mux_pol_eve), 0);
      chk("ch0_ovf.ovf", 32'(bus.out_ovf), 1);

      // Sticky: ch5 latched, then reset mid-frame discards it.
      do_reset("rst_ch5a");
      run_to(40, 1'b1);
      step(1'b1, 1'b1, 8'h20, 8'h20);
      run_to(50, 1'b1);
      do_reset("rst_ch5b");
      step(1'b1, 1'b1, '0, '0);
      chk("ch5.frame_first", 32'(bus.frame), 1);
      run_to(32, 1'b1);
      step(1'b1, 1'b1, '0, '0);
      chk("ch5.ch", 32'(bus.out_ch), 5);
      chk("ch5.eve", 32'(bus.out_mux_eve), 0);

      // Randomized run: stalls, mode switches, sparse events.
      do_reset("rst_rand");
      lm_r = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) lm_r = ~lm_r;
         for (int j = 0; j < N_CH; j++) ev_r[j] = ($urandom_range(0, 7) == 0);
         step($urandom_range(0, 9) != 0, lm_r, ev_r, N_CH'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
